// File: rtl/bram_frame_reader_pkg.sv
// Shared defaults, state encoding and derived widths for bram_frame_reader.
package bram_frame_reader_pkg;

    localparam int N_DEF     = 13;
    localparam int W_DEF     = 16;
    localparam int H_RES_DEF = 128;
    localparam int V_RES_DEF = 64;
    localparam int XW        = $clog2(H_RES_DEF);
    localparam int YW        = $clog2(V_RES_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of one buffered pixel entry {last, y, x, data}.
    function automatic int entry_width(input int xw, input int yw, input int dw);
        return 1 + yw + xw + dw;
    endfunction

endpackage

// File: rtl/bram_frame_reader_pix_skid_buf.sv
// pix_skid_buf: 2-entry FIFO holding {last, y, x, data}; head entry drives the
// output directly so valid/data never depend combinationally on ready.
module pix_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_count;
    logic          w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: raster-scans a frame BRAM onto a valid/ready pixel stream.
// Define BRAM_FRAME_READER_LOOP_EN for continuous frame looping.
module bram_frame_reader
    import bram_frame_reader_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int w     = W_DEF,
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [n-1:0]             bram_addr,
    output logic                     bram_read_write,
    input  logic [w-1:0]             bram_rdata,
    output logic [w-1:0]             pix_data,
    output logic [$clog2(H_RES)-1:0] pix_x,
    output logic [$clog2(V_RES)-1:0] pix_y,
    output logic                     pix_last,
    output logic                     pix_valid,
    input  logic                     pix_ready
);

    localparam int LXW = $clog2(H_RES);
    localparam int LYW = $clog2(V_RES);
    localparam int EW  = entry_width(LXW, LYW, w);
    localparam logic [n-1:0]   LAST_ADDR = n'(H_RES * V_RES - 1);
    localparam logic [LXW-1:0] X_MAX     = LXW'(H_RES - 1);

    state_t          r_state;
    logic [n-1:0]    r_addr;
    logic [LXW-1:0]  r_ix;
    logic [LYW-1:0]  r_iy;
    logic            r_inflight;
    logic [LXW-1:0]  r_fx;
    logic [LYW-1:0]  r_fy;
    logic            r_flast;
    logic            r_busy;
    logic            r_done;

    logic [EW-1:0]   w_head;
    logic [1:0]      w_count;
    logic            w_pop;
    logic [2:0]      w_level;
    logic            w_issue;
    logic            w_addr_last;

    assign bram_addr       = r_addr;
    assign bram_read_write = 1'b0;
    assign busy            = r_busy;
    assign done            = r_done;
    assign {pix_last, pix_y, pix_x, pix_data} = w_head;

    assign w_pop       = pix_valid && pix_ready;
    assign w_addr_last = (r_addr == LAST_ADDR);
    // A pop this cycle frees a slot, so counting it keeps 1 pixel/clk at full rate.
    assign w_level     = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue     = (r_state == ST_FETCH) && (w_level < (3'd2 + {2'b00, w_pop}));

    pix_skid_buf #(
        .DW(EW)
    ) u_skid (
        .clk    (clk),
        .clear  (clear),
        .i_push (r_inflight),
        .i_data ({r_flast, r_fy, r_fx, bram_rdata}),
        .o_valid(pix_valid),
        .i_ready(pix_ready),
        .o_data (w_head),
        .o_count(w_count)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_ix       <= '0;
            r_iy       <= '0;
            r_inflight <= 1'b0;
            r_fx       <= '0;
            r_fy       <= '0;
            r_flast    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= w_pop && pix_last;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fx    <= r_ix;
                r_fy    <= r_iy;
                r_flast <= w_addr_last;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_addr  <= '0;
                        r_ix    <= '0;
                        r_iy    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        if (w_addr_last) begin
`ifdef BRAM_FRAME_READER_LOOP_EN
                            r_addr <= '0;
                            r_ix   <= '0;
                            r_iy   <= '0;
`else
                            r_state <= ST_DRAIN;
`endif
                        end else begin
                            r_addr <= r_addr + n'(1);
                            if (r_ix == X_MAX) begin
                                r_ix <= '0;
                                r_iy <= r_iy + LYW'(1);
                            end else begin
                                r_ix <= r_ix + LXW'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && pix_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
